// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: ROM address/data, redirect input and the IF/ID handshake to decode.
// master = fetch_unit, slave = ROM/decode/branch side.
interface fetch_unit_if;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;
  logic [31:0] fetch_count;

  modport master (
    output rom_addr, out_valid, out_instr, out_pc, out_fault, fetch_count,
    input  rom_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  rom_addr, out_valid, out_instr, out_pc, out_fault, fetch_count,
    output rom_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// PC + IF/ID register: one word per cycle into decode, one-cycle fetch-to-output latency.
// Stalls on out_ready=0 (load blocked); redirect flushes; a fault parks the stage until redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_WORDS = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);
  localparam logic [31:0] ROM_LIMIT = 32'(4 * ROM_WORDS);

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        fault_now;
  logic        fire;
  logic        load;

  assign bus.rom_addr = pc;
  assign fault_now    = (pc[1:0] != 2'b00) || (pc >= ROM_LIMIT);
  assign fire         = bus.out_valid && bus.out_ready;
  assign load         = !bus.out_valid || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= RUN;
      pc              <= RESET_PC;
      bus.out_valid   <= 1'b0;
      bus.out_instr   <= '0;
      bus.out_pc      <= '0;
      bus.out_fault   <= 1'b0;
      bus.fetch_count <= '0;
    end else begin
      // Counted even when a redirect flushes: decode already took the word.
      if (fire)
        bus.fetch_count <= bus.fetch_count + 32'd1;

      case (state)
        RUN: begin
          if (bus.redirect_valid) begin
            pc            <= bus.redirect_pc;
            bus.out_valid <= 1'b0;
          end else if (load) begin
            bus.out_pc    <= pc;
            bus.out_valid <= 1'b1;
            if (fault_now) begin
              bus.out_instr <= NOP_INSTR;
              bus.out_fault <= 1'b1;
              state         <= FAULT;
            end else begin
              bus.out_instr <= bus.rom_data;
              bus.out_fault <= 1'b0;
              pc            <= pc + 32'd4;
            end
          end
        end
        FAULT: begin
          // Only a redirect leaves FAULT; the fault entry drains and nothing refills.
          if (bus.redirect_valid) begin
            pc            <= bus.redirect_pc;
            bus.out_valid <= 1'b0;
            state         <= RUN;
          end else if (fire) begin
            bus.out_valid <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written fault/reset sequences,
// then randomized traffic against a behavioural model.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0), .ROM_WORDS(32), .NOP_INSTR(NOP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [7:0] idx;
    idx = a[9:2];
    if (a[31:2] == 30'd1) return 32'h02A0_0093;
    if (a >= 32'd128)     return 32'hBAD0_0000 ^ a;
    return {8'hA5, idx, 16'h0013};
  endfunction

  always_comb bus.rom_data = rom_word(bus.rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic [31:0] rpc, input logic rdy);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
  endtask

  // Apply inputs for one cycle (called at a negedge), return at the next negedge.
  task automatic cyc(input logic rv, input logic [31:0] rpc, input logic rdy);
    drive(rv, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_entry(input string name, input logic vld, input logic [31:0] pc,
                           input logic flt, input logic [31:0] cnt, input logic [31:0] addr);
    chk({name, ".valid"}, {31'd0, bus.out_valid}, {31'd0, vld});
    chk({name, ".count"}, bus.fetch_count, cnt);
    chk({name, ".addr"},  bus.rom_addr, addr);
    if (vld) begin
      chk({name, ".pc"},    bus.out_pc, pc);
      chk({name, ".fault"}, {31'd0, bus.out_fault}, {31'd0, flt});
      chk({name, ".instr"}, bus.out_instr, flt ? NOP : rom_word(pc));
    end
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [31:0] e_cnt;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic rdy,
                              input logic v, input logic [31:0] p, input logic [31:0] c,
                              input logic [31:0] a);
    vec_t t;
    t.rv = rv; t.rpc = rpc; t.rdy = rdy;
    t.e_vld = v; t.e_pc = p; t.e_cnt = c; t.e_addr = a;
    return t;
  endfunction

  // Behavioural model state
  logic        m_vld, m_flt, m_halted;
  logic [31:0] m_pc, m_opc, m_instr, m_cnt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 32'h0, 1'b0);

    vecs[0]  = mk(0, 32'h00, 1, 1, 32'h00, 0, 32'h04);
    vecs[1]  = mk(0, 32'h00, 1, 1, 32'h04, 1, 32'h08);
    vecs[2]  = mk(0, 32'h00, 1, 1, 32'h08, 2, 32'h0C);
    vecs[3]  = mk(0, 32'h00, 0, 1, 32'h08, 2, 32'h0C);
    vecs[4]  = mk(0, 32'h00, 0, 1, 32'h08, 2, 32'h0C);
    vecs[5]  = mk(0, 32'h00, 0, 1, 32'h08, 2, 32'h0C);
    vecs[6]  = mk(0, 32'h00, 1, 1, 32'h0C, 3, 32'h10);
    vecs[7]  = mk(0, 32'h00, 1, 1, 32'h10, 4, 32'h14);
    vecs[8]  = mk(1, 32'h1C, 0, 0, 32'h00, 4, 32'h1C);
    vecs[9]  = mk(0, 32'h00, 0, 1, 32'h1C, 4, 32'h20);
    vecs[10] = mk(0, 32'h00, 1, 1, 32'h20, 5, 32'h24);
    vecs[11] = mk(0, 32'h00, 1, 1, 32'h24, 6, 32'h28);
    vecs[12] = mk(1, 32'h08, 1, 0, 32'h00, 7, 32'h08);
    vecs[13] = mk(0, 32'h00, 1, 1, 32'h08, 7, 32'h0C);
    vecs[14] = mk(1, 32'h40, 1, 0, 32'h00, 8, 32'h40);
    vecs[15] = mk(0, 32'h00, 1, 1, 32'h40, 8, 32'h44);
    vecs[16] = mk(1, 32'h44, 0, 0, 32'h00, 8, 32'h44);
    vecs[17] = mk(0, 32'h00, 0, 1, 32'h44, 8, 32'h48);

    // Reset state while held in reset
    @(negedge clk);
    @(negedge clk);
    chk_entry("reset", 0, 32'h0, 0, 32'h0, 32'h0);
    chk("reset.instr", bus.out_instr, 32'h0);
    chk("reset.pc", bus.out_pc, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      cyc(vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      chk_entry($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_pc, 1'b0,
                vecs[i].e_cnt, vecs[i].e_addr);
    end

    // Run off the end of the ROM
    cyc(1, 32'h78, 1); chk_entry("oor.redir", 0, 32'h0, 0, 9, 32'h78);
    cyc(0, 32'h00, 1); chk_entry("oor.w78", 1, 32'h78, 0, 9, 32'h7C);
    cyc(0, 32'h00, 1); chk_entry("oor.w7c", 1, 32'h7C, 0, 10, 32'h80);
    cyc(0, 32'h00, 1); chk_entry("oor.fault", 1, 32'h80, 1, 11, 32'h80);
    cyc(0, 32'h00, 0); chk_entry("oor.stall", 1, 32'h80, 1, 11, 32'h80);
    cyc(0, 32'h00, 1); chk_entry("oor.drain", 0, 32'h0, 0, 12, 32'h80);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 32'h00, 1); chk_entry("oor.parked", 0, 32'h0, 0, 12, 32'h80);
    end
    cyc(1, 32'h00, 1); chk_entry("oor.exit", 0, 32'h0, 0, 12, 32'h00);
    cyc(0, 32'h00, 1); chk_entry("oor.resume", 1, 32'h00, 0, 12, 32'h04);

    // Misaligned redirect, then async reset mid-stall
    cyc(1, 32'h06, 0); chk_entry("mis.redir", 0, 32'h0, 0, 12, 32'h06);
    cyc(0, 32'h00, 0); chk_entry("mis.fault", 1, 32'h06, 1, 12, 32'h06);
    cyc(0, 32'h00, 0); chk_entry("mis.stall", 1, 32'h06, 1, 12, 32'h06);
    #2;
    rst_n = 1'b0;
    #1;
    chk_entry("arst", 0, 32'h0, 0, 32'h0, 32'h0);
    chk("arst.instr", bus.out_instr, 32'h0);
    chk("arst.pc", bus.out_pc, 32'h0);
    chk("arst.fault", {31'd0, bus.out_fault}, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;

    // Randomized traffic against the model
    m_vld = 0; m_flt = 0; m_halted = 0;
    m_pc = 0; m_opc = 0; m_instr = 0; m_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      logic        rv, rdy, fire;
      logic [31:0] rpc;
      chk("rnd.valid", {31'd0, bus.out_valid}, {31'd0, m_vld});
      chk("rnd.addr", bus.rom_addr, m_pc);
      chk("rnd.count", bus.fetch_count, m_cnt);
      if (m_vld) begin
        chk("rnd.pc", bus.out_pc, m_opc);
        chk("rnd.instr", bus.out_instr, m_instr);
        chk("rnd.fault", {31'd0, bus.out_fault}, {31'd0, m_flt});
      end

      rv  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: rpc = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
        1: rpc = 32'h70 + 32'($urandom_range(0, 3)) * 4;
        2: rpc = {25'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(1, 3))};
        default: rpc = $urandom;
      endcase
      drive(rv, rpc, rdy);

      fire = m_vld && rdy;
      if (fire) m_cnt = m_cnt + 1;
      if (rv) begin
        m_pc = rpc;
        m_vld = 0;
        m_halted = 0;
      end else if (m_halted) begin
        if (fire) m_vld = 0;
      end else if (!m_vld || rdy) begin
        m_vld = 1;
        m_opc = m_pc;
        if (m_pc % 4 != 0 || m_pc >= 128) begin
          m_flt = 1; m_instr = NOP; m_halted = 1;
        end else begin
          m_flt = 0; m_instr = rom_word(m_pc); m_pc = m_pc + 4;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
